// File: rtl/wb_rr_arbiter_pkg.sv
// Shared types and constants for the two-master round-robin Wishbone arbiter.
package wb_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_A    = 2'b01;
  localparam logic [1:0] OWNER_B    = 2'b10;

endpackage

// File: rtl/wb_rr_arbiter_watchdog.sv
// Bus-ownership watchdog: counts idle owned clocks and flags when the count saturates.
module wb_watchdog #(
  parameter int LG = 10
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  logic [LG-1:0] count;

  assign o_expired = (count == '1);

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear || !i_run)
      count <= '0;
    else if (!o_expired)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone (pipelined) arbiter; grant is registered, bus paths are combinational.
// Optional ownership watchdog enabled by defining WB_RR_ARBITER_TIMEOUT_EN.
module wb_rr_arbiter
  import wb_rr_arbiter_pkg::*;
#(
  parameter int       AW           = 26,
  parameter int       DW           = 32,
  parameter logic     OPT_LOWPOWER = 1'b0,
  parameter int       TIMEOUT_LG   = 10
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_a_cyc,
  input  logic            i_a_stb,
  input  logic            i_a_we,
  input  logic [AW-1:0]   i_a_addr,
  input  logic [DW-1:0]   i_a_data,
  input  logic [DW/8-1:0] i_a_sel,
  output logic            o_a_stall,
  output logic            o_a_ack,
  output logic            o_a_err,
  input  logic            i_b_cyc,
  input  logic            i_b_stb,
  input  logic            i_b_we,
  input  logic [AW-1:0]   i_b_addr,
  input  logic [DW-1:0]   i_b_data,
  input  logic [DW/8-1:0] i_b_sel,
  output logic            o_b_stall,
  output logic            o_b_ack,
  output logic            o_b_err,
  output logic [DW-1:0]   o_rdata,
  output logic            o_cyc,
  output logic            o_stb,
  output logic            o_we,
  output logic [AW-1:0]   o_addr,
  output logic [DW-1:0]   o_data,
  output logic [DW/8-1:0] o_sel,
  input  logic            i_stall,
  input  logic            i_ack,
  input  logic            i_err,
  input  logic [DW-1:0]   i_data,
  output logic [1:0]      o_owner
);

  state_t     state, state_n;
  logic       last_b, last_b_n;
  logic [1:0] owner_n;
  logic       own_a, own_b, abort, req_a, req_b, expire;

  assign own_a = (state == OWN_A);
  assign own_b = (state == OWN_B);
  assign abort = (state == ABORT);
  assign req_a = i_a_cyc & i_a_stb;
  assign req_b = i_b_cyc & i_b_stb;

`ifdef WB_RR_ARBITER_TIMEOUT_EN
  logic wd_full;

  wb_watchdog #(.LG(TIMEOUT_LG)) u_watchdog (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_clear   ((state == IDLE) | i_ack | (o_stb & ~i_stall)),
    .i_run     (own_a | own_b),
    .o_expired (wd_full)
  );

  assign expire = wd_full & ((own_a & i_a_cyc) | (own_b & i_b_cyc));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LG;
  assign expire = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    last_b_n = last_b;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || last_b)) begin
          state_n  = OWN_A;
          last_b_n = 1'b0;
        end else if (req_b) begin
          state_n  = OWN_B;
          last_b_n = 1'b1;
        end
      end
      OWN_A: begin
        if (!i_a_cyc)    state_n = IDLE;
        else if (expire) state_n = ABORT;
      end
      OWN_B: begin
        if (!i_b_cyc)    state_n = IDLE;
        else if (expire) state_n = ABORT;
      end
`ifdef WB_RR_ARBITER_TIMEOUT_EN
      // last_b still names the aborted owner, since ABORT never updates it
      ABORT: if (!(last_b ? i_b_cyc : i_a_cyc)) state_n = IDLE;
`endif
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    case (state_n)
      OWN_A:   owner_n = OWNER_A;
      OWN_B:   owner_n = OWNER_B;
      default: owner_n = OWNER_NONE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      o_owner <= OWNER_NONE;
    end else begin
      state   <= state_n;
      last_b  <= last_b_n;
      o_owner <= owner_n;
    end
  end

  always_comb begin
    o_cyc = (own_a & i_a_cyc) | (own_b & i_b_cyc);
    o_stb = (own_a & i_a_stb) | (own_b & i_b_stb);
    if (OPT_LOWPOWER && !o_stb) begin
      o_we   = 1'b0;
      o_addr = '0;
      o_data = '0;
      o_sel  = '0;
    end else if (own_b) begin
      o_we   = i_b_we;
      o_addr = i_b_addr;
      o_data = i_b_data;
      o_sel  = i_b_sel;
    end else begin
      o_we   = i_a_we;
      o_addr = i_a_addr;
      o_data = i_a_data;
      o_sel  = i_a_sel;
    end
  end

  always_comb begin
    o_a_stall = own_a ? i_stall : (abort | i_a_stb);
    o_b_stall = own_b ? i_stall : (abort | i_b_stb);
    o_a_ack   = own_a & i_ack & i_a_cyc;
    o_b_ack   = own_b & i_ack & i_b_cyc;
    o_a_err   = own_a & ((i_err & i_a_cyc) | expire);
    o_b_err   = own_b & ((i_err & i_b_cyc) | expire);
    o_rdata   = (OPT_LOWPOWER && !o_cyc) ? '0 : i_data;
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed scenarios plus randomized traffic against an ownership model.
module tb_wb_rr_arbiter;

  localparam int   AW = 26;
  localparam int   DW = 32;
  localparam logic LP = 1'b0;
  localparam int   TLG = 10;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic            i_a_cyc, i_a_stb, i_a_we;
  logic [AW-1:0]   i_a_addr;
  logic [DW-1:0]   i_a_data;
  logic [DW/8-1:0] i_a_sel;
  logic            o_a_stall, o_a_ack, o_a_err;
  logic            i_b_cyc, i_b_stb, i_b_we;
  logic [AW-1:0]   i_b_addr;
  logic [DW-1:0]   i_b_data;
  logic [DW/8-1:0] i_b_sel;
  logic            o_b_stall, o_b_ack, o_b_err;
  logic [DW-1:0]   o_rdata;
  logic            o_cyc, o_stb, o_we;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_data;
  logic [DW/8-1:0] o_sel;
  logic            i_stall, i_ack, i_err;
  logic [DW-1:0]   i_data;
  logic [1:0]      o_owner;

  int errors = 0;
  int checks = 0;
  bit model_en = 1'b1;

  // Model: who owns the bus (0 none, 1 A, 2 B) and who won the most recent grant.
  int m_owner = 0;
  int m_last  = 2;

  always #5 i_clk = ~i_clk;

  wb_rr_arbiter #(.AW(AW), .DW(DW), .OPT_LOWPOWER(LP), .TIMEOUT_LG(TLG)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_cyc(i_a_cyc), .i_a_stb(i_a_stb), .i_a_we(i_a_we), .i_a_addr(i_a_addr),
    .i_a_data(i_a_data), .i_a_sel(i_a_sel),
    .o_a_stall(o_a_stall), .o_a_ack(o_a_ack), .o_a_err(o_a_err),
    .i_b_cyc(i_b_cyc), .i_b_stb(i_b_stb), .i_b_we(i_b_we), .i_b_addr(i_b_addr),
    .i_b_data(i_b_data), .i_b_sel(i_b_sel),
    .o_b_stall(o_b_stall), .o_b_ack(o_b_ack), .o_b_err(o_b_err),
    .o_rdata(o_rdata), .o_cyc(o_cyc), .o_stb(o_stb), .o_we(o_we), .o_addr(o_addr),
    .o_data(o_data), .o_sel(o_sel),
    .i_stall(i_stall), .i_ack(i_ack), .i_err(i_err), .i_data(i_data),
    .o_owner(o_owner)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge i_clk) begin
    if (i_reset) begin
      m_owner = 0;
      m_last  = 2;
    end else if (m_owner == 0) begin
      if (i_a_cyc && i_a_stb && !(i_b_cyc && i_b_stb && m_last == 1)) begin
        m_owner = 1; m_last = 1;
      end else if (i_b_cyc && i_b_stb) begin
        m_owner = 2; m_last = 2;
      end
    end else if ((m_owner == 1 && !i_a_cyc) || (m_owner == 2 && !i_b_cyc)) begin
      m_owner = 0;
    end
  end

  always @(negedge i_clk) begin
    if (model_en) begin
      logic e_cyc, e_stb, e_we;
      logic [AW-1:0]   e_addr;
      logic [DW-1:0]   e_data;
      logic [DW/8-1:0] e_sel;
      e_cyc = 1'b0; e_stb = 1'b0; e_we = 1'b0; e_addr = '0; e_data = '0; e_sel = '0;
      if (m_owner == 1) begin
        e_cyc = i_a_cyc; e_stb = i_a_stb; e_we = i_a_we; e_addr = i_a_addr; e_data = i_a_data; e_sel = i_a_sel;
      end else if (m_owner == 2) begin
        e_cyc = i_b_cyc; e_stb = i_b_stb; e_we = i_b_we; e_addr = i_b_addr; e_data = i_b_data; e_sel = i_b_sel;
      end
      chk("m_owner", 64'(o_owner), 64'(m_owner));
      chk("m_cyc", 64'(o_cyc), 64'(e_cyc));
      chk("m_stb", 64'(o_stb), 64'(e_stb));
      if (e_stb || LP) begin
        chk("m_we", 64'(o_we), 64'(e_stb ? e_we : 1'b0));
        chk("m_addr", 64'(o_addr), 64'(e_stb ? e_addr : '0));
        chk("m_data", 64'(o_data), 64'(e_stb ? e_data : '0));
        chk("m_sel", 64'(o_sel), 64'(e_stb ? e_sel : '0));
      end
      chk("m_a_stall", 64'(o_a_stall), 64'(m_owner == 1 ? i_stall : i_a_stb));
      chk("m_b_stall", 64'(o_b_stall), 64'(m_owner == 2 ? i_stall : i_b_stb));
      chk("m_a_ack", 64'(o_a_ack), 64'(m_owner == 1 && i_ack && i_a_cyc));
      chk("m_b_ack", 64'(o_b_ack), 64'(m_owner == 2 && i_ack && i_b_cyc));
      chk("m_a_err", 64'(o_a_err), 64'(m_owner == 1 && i_err && i_a_cyc));
      chk("m_b_err", 64'(o_b_err), 64'(m_owner == 2 && i_err && i_b_cyc));
      chk("m_rdata", 64'(o_rdata), 64'((LP && !e_cyc) ? '0 : i_data));
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_inputs;
    i_a_cyc = 0; i_a_stb = 0; i_a_we = 0; i_a_addr = '0; i_a_data = '0; i_a_sel = '0;
    i_b_cyc = 0; i_b_stb = 0; i_b_we = 0; i_b_addr = '0; i_b_data = '0; i_b_sel = '0;
    i_stall = 0; i_ack = 0; i_err = 0; i_data = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    i_reset = 1;
    tick();
    i_reset = 0;
  endtask

  initial begin
    logic [1:0] stall_pat [5];
    int acc;
    stall_pat = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd0};
    clear_inputs();
    i_reset = 1;
    tick(); tick();
    i_reset = 0;
    settle();
    chk("rst_owner", 64'(o_owner), 64'd0);
    chk("rst_cyc", 64'(o_cyc), 64'd0);
    chk("rst_stb", 64'(o_stb), 64'd0);

    // Single master A read
    i_a_cyc = 1; i_a_stb = 1; i_a_addr = 26'h10;
    settle();
    chk("a_req_stall", 64'(o_a_stall), 64'd1);
    chk("a_req_cyc", 64'(o_cyc), 64'd0);
    tick();
    chk("a_grant_owner", 64'(o_owner), 64'h1);
    chk("a_grant_addr", 64'(o_addr), 64'h10);
    chk("a_grant_stall", 64'(o_a_stall), 64'd0);
    tick(); i_a_stb = 0;
    tick(); i_ack = 1; i_data = 32'hDEADBEEF;
    settle();
    chk("a_ack", 64'(o_a_ack), 64'd1);
    chk("a_rdata", 64'(o_rdata), 64'hDEADBEEF);
    chk("a_b_ack", 64'(o_b_ack), 64'd0);
    tick(); i_ack = 0; i_a_cyc = 0;
    settle();
    chk("a_rel_cyc", 64'(o_cyc), 64'd0);
    tick();
    chk("a_rel_owner", 64'(o_owner), 64'd0);

    // Tie from reset, then alternation
    do_reset();
    i_a_cyc = 1; i_a_stb = 1; i_b_cyc = 1; i_b_stb = 1;
    tick();
    chk("tie1_owner", 64'(o_owner), 64'h1);
    chk("tie1_b_stall", 64'(o_b_stall), 64'd1);
    i_a_stb = 0;
    tick(); i_a_cyc = 0;
    tick();
    chk("gap_owner", 64'(o_owner), 64'd0);
    chk("gap_b_stall", 64'(o_b_stall), 64'd1);
    tick();
    chk("b_owner", 64'(o_owner), 64'h2);
    i_a_cyc = 1; i_a_stb = 1; i_b_cyc = 0; i_b_stb = 0;
    tick();
    chk("gap2_owner", 64'(o_owner), 64'd0);
    i_b_cyc = 1; i_b_stb = 1;
    tick();
    chk("tie2_owner", 64'(o_owner), 64'h1);

    // Pipelined writes with stalls, B waiting
    do_reset();
    i_a_cyc = 1; i_a_stb = 1; i_a_we = 1; i_a_addr = 26'h20; i_b_cyc = 1; i_b_stb = 1;
    tick();
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      i_stall = stall_pat[i][0];
      settle();
      chk("pw_a_stall", 64'(o_a_stall), 64'(stall_pat[i][0]));
      chk("pw_b_stall", 64'(o_b_stall), 64'd1);
      chk("pw_addr", 64'(o_addr), 64'(26'h20 + acc));
      if (!stall_pat[i][0]) begin
        acc++;
        tick();
        i_a_addr = i_a_addr + 1'b1;
      end else begin
        tick();
      end
    end
    i_a_stb = 0; i_stall = 0; i_ack = 1;
    tick(); i_ack = 0; i_err = 1;
    settle();
    chk("err_a", 64'(o_a_err), 64'd1);
    chk("err_b", 64'(o_b_err), 64'd0);
    tick(); i_err = 0; i_a_cyc = 0;
    tick();
    chk("err_idle", 64'(o_owner), 64'd0);
    tick();
    chk("err_b_grant", 64'(o_owner), 64'h2);

    // Reset while B owns the bus with a strobe pending
    i_ack = 1; i_err = 1; i_reset = 1;
    tick();
    chk("rstb_owner", 64'(o_owner), 64'd0);
    chk("rstb_cyc", 64'(o_cyc), 64'd0);
    chk("rstb_ack", 64'(o_b_ack), 64'd0);
    chk("rstb_err", 64'(o_b_err), 64'd0);
    i_reset = 0; i_ack = 0; i_err = 0;
    tick();

`ifdef WB_RR_ARBITER_TIMEOUT_EN
    begin
      int k;
      model_en = 0;
      do_reset();
      i_a_cyc = 1; i_a_stb = 1; i_stall = 1;
      tick();
      k = -1;
      for (int i = 0; i < (1 << TLG) + 64; i++) begin
        if (o_a_err) begin k = i; break; end
        tick();
      end
      chk("wd_expire_at", 64'(k), 64'((1 << TLG) - 1));
      tick();
      chk("wd_cyc_off", 64'(o_cyc), 64'd0);
      chk("wd_err_once", 64'(o_a_err), 64'd0);
      chk("wd_a_stall", 64'(o_a_stall), 64'd1);
      i_ack = 1;
      tick();
      chk("wd_hold_cyc", 64'(o_cyc), 64'd0);
      chk("wd_hold_ack", 64'(o_a_ack), 64'd0);
      i_ack = 0; i_a_cyc = 0; i_a_stb = 0;
      tick();
      i_a_cyc = 1; i_a_stb = 1; i_stall = 0;
      tick();
      chk("wd_regrant", 64'(o_owner), 64'h1);
      do_reset();
      model_en = 1;
    end
`endif

    // Randomized traffic; protocol compliance is unnecessary since the model covers any input.
    do_reset();
    repeat (3000) begin
      if (i_a_cyc) begin if ($urandom_range(7) == 0) i_a_cyc = 0; end
      else if ($urandom_range(3) == 0) i_a_cyc = 1;
      if (i_b_cyc) begin if ($urandom_range(7) == 0) i_b_cyc = 0; end
      else if ($urandom_range(3) == 0) i_b_cyc = 1;
      i_a_stb  = i_a_cyc ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      i_b_stb  = i_b_cyc ? ($urandom_range(1) == 1) : ($urandom_range(7) == 0);
      i_a_we   = ($urandom_range(1) == 1);
      i_b_we   = ($urandom_range(1) == 1);
      i_a_addr = AW'($urandom);
      i_b_addr = AW'($urandom);
      i_a_data = $urandom;
      i_b_data = $urandom;
      i_a_sel  = 4'($urandom);
      i_b_sel  = 4'($urandom);
      i_stall  = ($urandom_range(2) == 0);
      i_ack    = ($urandom_range(2) == 0);
      i_err    = ($urandom_range(15) == 0);
      i_data   = $urandom;
      i_reset  = ($urandom_range(99) == 0);
      tick();
    end
    i_reset = 0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
